// File: rtl/pgm8755_sequencer.sv
// Sequences one read, program or program+verify cycle on the 8755 multiplexed AD bus.
// Outputs are registered from the next state, so pins track the FSM state cycle-for-cycle.
module pgm8755_sequencer #(
  parameter int T_SU   = 2,
  parameter int T_ALE  = 4,
  parameter int T_HOLD = 2,
  parameter int T_PROG = 2500000,
  parameter int T_REC  = 50,
  parameter int T_RD   = 8,
  parameter int CNT_W  = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [10:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        abort,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic [2:0]  addr_hi,
  output logic        ale,
  output logic        rd_n,
  output logic        prog,
  output logic        busy,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [7:0]  rsp_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ALE_HI, S_HOLD, S_DATA, S_PROG, S_REC, S_READ, S_DONE
  } state_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_VERIFY = 2'b10;
  localparam logic [1:0] OP_ILL    = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MISM    = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
  localparam logic [1:0] ST_ABORTED = 2'b11;

  localparam logic [CNT_W-1:0] LD_SU   = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] LD_ALE  = CNT_W'(T_ALE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_PROG = CNT_W'(T_PROG - 1);
  localparam logic [CNT_W-1:0] LD_REC  = CNT_W'(T_REC - 1);
  localparam logic [CNT_W-1:0] LD_RD   = CNT_W'(T_RD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       op_q, op_d;
  logic [10:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       status_q, status_d;
  logic [7:0]       rdata_q, rdata_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic [7:0]       ad_out_q, ad_out_d;
  logic             ad_oe_q, ad_oe_d;
  logic [2:0]       addr_hi_q, addr_hi_d;
  logic             ale_q, ale_d;
  logic             rd_n_q, rd_n_d;
  logic             prog_q, prog_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [7:0]       rsp_data_q, rsp_data_d;

  logic             tmr_zero;
  assign tmr_zero = (timer_q == '0);

  always_comb begin
    state_d  = state_q;
    timer_d  = tmr_zero ? '0 : timer_q - CNT_W'(1);
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    status_d = status_q;
    rdata_d  = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          rdata_d = '0;
          if (cmd_op == OP_ILL) begin
            state_d  = S_DONE;
            status_d = ST_ILLEGAL;
          end else begin
            state_d  = S_ADDR;
            timer_d  = LD_SU;
            status_d = ST_OK;
          end
        end
      end
      S_ADDR: if (tmr_zero) begin
        state_d = S_ALE_HI;
        timer_d = LD_ALE;
      end
      S_ALE_HI: if (tmr_zero) begin
        state_d = S_HOLD;
        timer_d = LD_HOLD;
      end
      S_HOLD: if (tmr_zero) begin
        if (op_q == OP_READ) begin
          state_d = S_READ;
          timer_d = LD_RD;
        end else begin
          state_d = S_DATA;
          timer_d = LD_SU;
        end
      end
      S_DATA: if (tmr_zero) begin
        state_d = S_PROG;
        timer_d = LD_PROG;
      end
      S_PROG: if (tmr_zero) begin
        state_d = S_REC;
        timer_d = LD_REC;
      end
      S_REC: if (tmr_zero) begin
        if (op_q == OP_VERIFY) begin
          state_d = S_READ;
          timer_d = LD_RD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_READ: if (tmr_zero) begin
        // Sample on the last strobe cycle so the EPROM has the full T_RD access time.
        rdata_d = ad_in;
        if (op_q == OP_VERIFY && ad_in != data_q) status_d = ST_MISM;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any timer expiry in the same cycle, including the read capture.
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d  = S_DONE;
      status_d = ST_ABORTED;
      rdata_d  = '0;
    end
  end

  always_comb begin
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    ad_out_d     = '0;
    ad_oe_d      = 1'b0;
    addr_hi_d    = addr_hi_q;
    ale_d        = 1'b0;
    rd_n_d       = 1'b1;
    prog_d       = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_status_d = '0;
    rsp_data_d   = '0;

    case (state_d)
      S_ADDR, S_ALE_HI, S_HOLD: begin
        ad_oe_d   = 1'b1;
        ad_out_d  = addr_d[7:0];
        addr_hi_d = addr_d[10:8];
        ale_d     = (state_d == S_ALE_HI);
      end
      S_DATA, S_PROG, S_REC: begin
        ad_oe_d  = 1'b1;
        ad_out_d = data_d;
        prog_d   = (state_d == S_PROG);
      end
      S_READ: rd_n_d = 1'b0;
      S_DONE: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = status_d;
        rsp_data_d   = rdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      status_q     <= '0;
      rdata_q      <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      ad_out_q     <= '0;
      ad_oe_q      <= 1'b0;
      addr_hi_q    <= '0;
      ale_q        <= 1'b0;
      rd_n_q       <= 1'b1;
      prog_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      status_q     <= status_d;
      rdata_q      <= rdata_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      addr_hi_q    <= addr_hi_d;
      ale_q        <= ale_d;
      rd_n_q       <= rd_n_d;
      prog_q       <= prog_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign ad_out     = ad_out_q;
  assign ad_oe      = ad_oe_q;
  assign addr_hi    = addr_hi_q;
  assign ale        = ale_q;
  assign rd_n       = rd_n_q;
  assign prog       = prog_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_pgm8755_sequencer.sv
// Directed bench for pgm8755_sequencer with short timing parameters and a simple EPROM read model.
module tb_pgm8755_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        abort;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  ad_in;
  logic [2:0]  addr_hi;
  logic        ale;
  logic        rd_n;
  logic        prog;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_data;

  logic [7:0]  model_byte;
  assign ad_in = rd_n ? 8'h00 : model_byte;

  always #5 clk = ~clk;

  pgm8755_sequencer #(
    .T_SU(1), .T_ALE(2), .T_HOLD(1), .T_PROG(5), .T_REC(2), .T_RD(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .abort(abort),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .addr_hi(addr_hi),
    .ale(ale), .rd_n(rd_n), .prog(prog), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         r_lat, r_acc_wait, r_prog_cnt, r_ale_cnt, r_ale_bad, r_prog_bad, r_read_oe;
  logic       r_got, r_bus, r_abort_prog, r_done_bus;
  logic [1:0] r_status;
  logic [7:0] r_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. r_lat = number of rising edges after the accept edge up to and
  // including the edge that samples rsp_valid high.
  task automatic run(input logic [1:0] op, input logic [10:0] addr, input logic [7:0] data,
                     input int abort_at);
    logic rdy;
    r_lat = 0; r_acc_wait = 0; r_prog_cnt = 0; r_ale_cnt = 0; r_ale_bad = 0;
    r_prog_bad = 0; r_read_oe = 0; r_got = 0; r_bus = 0; r_abort_prog = 1'b1;
    r_done_bus = 1'b1; r_status = 2'bxx; r_rdata = 8'hxx;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    for (int w = 0; w < 20; w++) begin
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) break;
      r_acc_wait++;
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (ale) begin
        r_ale_cnt++;
        if (ad_out !== addr[7:0] || addr_hi !== addr[10:8] || ad_oe !== 1'b1) r_ale_bad++;
      end
      if (prog) begin
        r_prog_cnt++;
        if (ad_out !== data || ad_oe !== 1'b1) r_prog_bad++;
      end
      if (!rd_n && ad_oe) r_read_oe++;
      if (ale || prog || ad_oe) r_bus = 1'b1;
      if (abort) begin
        abort = 1'b0;
        r_abort_prog = prog;
      end
      if (abort_at > 0 && prog && r_prog_cnt == abort_at) abort = 1'b1;
      if (rsp_valid) begin
        r_got = 1'b1; r_lat = i; r_status = rsp_status; r_rdata = rsp_data;
        r_done_bus = ale | prog | ad_oe | ~rd_n;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_seen", 32'(r_got), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, 32'({cmd_ready, busy, ad_oe, ale, rd_n, prog, rsp_valid}), 32'b1000100);
    chk({tag, "_dat"}, {ad_out, 5'd0, addr_hi, 6'd0, rsp_status, rsp_data}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    abort = 1'b0; model_byte = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Program 0x7FF/0xA5: 1+2+1+1+5+2 = 12 state cycles, response sampled at edge 13.
    run(2'b01, 11'h7FF, 8'hA5, 0);
    chk("prog_lat", r_lat, 32'd13);
    chk("prog_status", 32'(r_status), 32'd0);
    chk("prog_pulse_cycles", r_prog_cnt, 32'd5);
    chk("prog_data_drive_bad", r_prog_bad, 32'd0);
    chk("ale_cycles", r_ale_cnt, 32'd2);
    chk("ale_addr_drive_bad", r_ale_bad, 32'd0);
    chk("prog_rdata", 32'(r_rdata), 32'd0);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("addr_hi_held", 32'(addr_hi), 32'd7);

    // Program+verify, matching then mismatching read-back; second issued back-to-back.
    model_byte = 8'h3C;
    run(2'b10, 11'h123, 8'h3C, 0);
    chk("verify_lat", r_lat, 32'd15);
    chk("verify_ok_status", 32'(r_status), 32'd0);
    chk("verify_ok_rdata", 32'(r_rdata), 32'h3C);
    model_byte = 8'h3D;
    run(2'b10, 11'h123, 8'h3C, 0);
    chk("b2b_accept_wait", r_acc_wait, 32'd1);
    chk("verify_mism_status", 32'(r_status), 32'd1);
    chk("verify_mism_rdata", 32'(r_rdata), 32'h3D);

    // Read: 1+2+1+2 = 6 state cycles, response sampled at edge 7.
    model_byte = 8'h9E;
    run(2'b00, 11'h055, 8'h00, 0);
    chk("read_lat", r_lat, 32'd7);
    chk("read_status", 32'(r_status), 32'd0);
    chk("read_rdata", 32'(r_rdata), 32'h9E);
    chk("read_oe_during_rd", r_read_oe, 32'd0);
    chk("read_no_prog", r_prog_cnt, 32'd0);

    // Illegal op goes straight to DONE with no bus activity.
    run(2'b11, 11'h3AA, 8'h11, 0);
    chk("illegal_lat", r_lat, 32'd1);
    chk("illegal_status", 32'(r_status), 32'd2);
    chk("illegal_bus_activity", 32'(r_bus), 32'd0);

    // Abort on the third PROG cycle, then a clean read.
    run(2'b01, 11'h200, 8'h5A, 3);
    chk("abort_prog_next", 32'(r_abort_prog), 32'd0);
    chk("abort_status", 32'(r_status), 32'd3);
    chk("abort_done_bus", 32'(r_done_bus), 32'd0);
    chk("abort_prog_cycles", r_prog_cnt, 32'd3);
    model_byte = 8'hC3;
    run(2'b00, 11'h001, 8'h00, 0);
    chk("post_abort_lat", r_lat, 32'd7);
    chk("post_abort_status", 32'(r_status), 32'd0);
    chk("post_abort_rdata", 32'(r_rdata), 32'hC3);

    // Reset mid-PROG after a command was offered while busy.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 11'h4F0; cmd_data = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (prog) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("reset_test_prog_seen", seen, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 11'h010;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_prog_reset");
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("no_stale_response", seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
